// File: rtl/higher_memory_arbiter.sv
// ----------------------------------------------------------------------------
// higher_memory_arbiter
//
// Arbitrates two requesters onto a single higher-memory port. One downstream
// transaction is in flight at a time. When both requesters are pending in the
// same IDLE cycle, a round-robin pointer decides the grant. A watchdog sets a
// sticky flag when a transaction waits too long, but it never aborts the
// transaction.
//
// Parameters
//   XLEN            data/address width
//   TIMEOUT_CYCLES  BUSY cycles without completion before timeout_error (>=2)
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   rN_req_address/operation/
//     store_word/valid            requester N request (held until fulfilled)
//   rN_req_loaded_word/fulfilled  requester N completion (combinational)
//   mem_req_address/operation/
//     store_word/valid            registered request to higher memory
//   mem_req_loaded_word/fulfilled completion from higher memory
//   owner                         current/last granted requester
//   busy                          transaction in flight
//   timeout_error                 sticky watchdog flag
// ----------------------------------------------------------------------------

package higher_memory_arbiter_pkg;

   typedef enum logic {
      MEM_LOAD  = 1'b0,
      MEM_STORE = 1'b1
   } memory_operation_e;

endpackage : higher_memory_arbiter_pkg

module higher_memory_arbiter
   import higher_memory_arbiter_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic [XLEN-1:0]   r0_req_address,
   input  memory_operation_e r0_req_operation,
   input  logic [XLEN-1:0]   r0_req_store_word,
   input  logic              r0_req_valid,
   output logic [XLEN-1:0]   r0_req_loaded_word,
   output logic              r0_req_fulfilled,

   input  logic [XLEN-1:0]   r1_req_address,
   input  memory_operation_e r1_req_operation,
   input  logic [XLEN-1:0]   r1_req_store_word,
   input  logic              r1_req_valid,
   output logic [XLEN-1:0]   r1_req_loaded_word,
   output logic              r1_req_fulfilled,

   output logic [XLEN-1:0]   mem_req_address,
   output memory_operation_e mem_req_operation,
   output logic [XLEN-1:0]   mem_req_store_word,
   output logic              mem_req_valid,
   input  logic [XLEN-1:0]   mem_req_loaded_word,
   input  logic              mem_req_fulfilled,

   output logic              owner,
   output logic              busy,
   output logic              timeout_error
);

   // Watchdog counter is wide enough to hold TIMEOUT_CYCLES itself, where it
   // saturates.
   localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_ARM   = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e          state;
   state_e          state_next;
   logic            prio;       // requester that wins the next contested grant
   logic [WD_W-1:0] wd_cnt;

   logic            grant;
   logic            grant_sel;
   logic            contested;
   logic            completing;

   // -------------------------------------------------------------------------
   // Grant decision. Only IDLE may grant, so inputs of the non-owner are
   // never looked at while a transaction is in flight; a pending non-owner
   // simply stays pending until the next IDLE cycle.
   // -------------------------------------------------------------------------
   assign contested  = r0_req_valid && r1_req_valid;
   assign grant      = (state == IDLE) && (r0_req_valid || r1_req_valid);
   // Uncontested: the single valid requester wins (r1 iff r1 is the one).
   assign grant_sel  = contested ? prio : r1_req_valid;
   // mem_req_fulfilled only counts while BUSY; in IDLE it is ignored.
   assign completing = (state == BUSY) && mem_req_fulfilled;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant)      state_next = BUSY;
         BUSY:    if (completing) state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs. Completion is routed combinationally to the owner only;
   // the other requester sees fulfilled=0 and a zero loaded word.
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      busy               = (state == BUSY);
      r0_req_fulfilled   = 1'b0;
      r1_req_fulfilled   = 1'b0;
      r0_req_loaded_word = '0;
      r1_req_loaded_word = '0;
      if (completing) begin
         if (owner == 1'b0) begin
            r0_req_fulfilled   = 1'b1;
            r0_req_loaded_word = mem_req_loaded_word;
         end else begin
            r1_req_fulfilled   = 1'b1;
            r1_req_loaded_word = mem_req_loaded_word;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registered downstream request, owner and round-robin pointer. The
   // request is captured once at grant and held for the whole transaction.
   // -------------------------------------------------------------------------
   // NOTE: the address/data registers are reset too, even though they are
   // qualified by mem_req_valid, so the memory port reads all-zero in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req_valid      <= 1'b0;
         mem_req_address    <= '0;
         mem_req_store_word <= '0;
         mem_req_operation  <= MEM_LOAD;
         owner              <= 1'b0;
         prio               <= 1'b0;
      end else if (grant) begin
         mem_req_valid <= 1'b1;
         owner         <= grant_sel;
         if (grant_sel == 1'b0) begin
            mem_req_address    <= r0_req_address;
            mem_req_store_word <= r0_req_store_word;
            mem_req_operation  <= r0_req_operation;
         end else begin
            mem_req_address    <= r1_req_address;
            mem_req_store_word <= r1_req_store_word;
            mem_req_operation  <= r1_req_operation;
         end
         // Pointer moves only on a contested grant, so a lone requester can
         // stream without the pointer drifting.
         if (contested) begin
            prio <= ~grant_sel;
         end
      end else if (completing) begin
         mem_req_valid <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Watchdog. Cleared on grant, counts BUSY cycles without completion and
   // saturates at the limit. The flag is raised on the edge where the count
   // reaches TIMEOUT_CYCLES and stays up until reset; the transaction keeps
   // waiting for the memory.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt        <= '0;
         timeout_error <= 1'b0;
      end else begin
         if (grant) begin
            wd_cnt <= '0;
         end else if ((state == BUSY) && !mem_req_fulfilled && (wd_cnt != WD_LIMIT)) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if ((state == BUSY) && !mem_req_fulfilled && (wd_cnt == WD_ARM)) begin
            timeout_error <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Protocol properties
   // -------------------------------------------------------------------------
   a_single_completion : assert property (
      @(posedge clk) disable iff (!reset_n)
      !(r0_req_fulfilled && r1_req_fulfilled)
   );

   a_request_held : assert property (
      @(posedge clk) disable iff (!reset_n)
      (busy && !mem_req_fulfilled) |=>
         ($stable(mem_req_address) && $stable(mem_req_store_word) &&
          $stable(mem_req_operation) && mem_req_valid)
   );

endmodule : higher_memory_arbiter
